// File: rtl/letc_core_pkg.sv
// letc_core_pkg: shared LETC Core types.
//   limp_req_t       - one LIMP request (direction, cacheability, size, address, write data)
//   limp_arb_state_e - LIMP arbiter FSM states
//   idx_width()      - index width for an n-entry selector, never less than 1
package letc_core_pkg;

  typedef logic [31:0] word_t;
  typedef logic [33:0] paddr_t;

  typedef enum logic [1:0] {
    SIZE_BYTE     = 2'b00,
    SIZE_HALFWORD = 2'b01,
    SIZE_WORD     = 2'b10
  } size_e;

  typedef struct packed {
    logic   wen_nren;     // 1 = write, 0 = read
    logic   uncacheable;
    size_e  size;
    paddr_t addr;
    word_t  wdata;
  } limp_req_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_ABORT
  } limp_arb_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/letc_core_rr_picker.sv
// letc_core_rr_picker: combinational round-robin first-set search.
//   i_req   [W]  request vector
//   i_ptr   [IW] search start position (must be < W)
//   o_idx   [IW] first set bit at or after i_ptr, wrapping modulo W
//   o_found      any bit of i_req is set
module letc_core_rr_picker #(
  parameter  int W  = 2,
  localparam int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_idx,
  output logic          o_found
);

  logic [2*W-1:0] dbl;
  logic [W-1:0]   rot;
  logic [IW-1:0]  off;
  logic [IW:0]    sum;

  // Rotate so bit 0 of rot is request i_ptr; the lowest set bit of rot is
  // then the winner's distance from the pointer.
  assign dbl = {i_req, i_req};
  assign rot = W'(dbl >> i_ptr);

  always_comb begin
    off     = '0;
    o_found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off     = IW'(i);
        o_found = 1'b1;
      end
    end
  end

  // One extra bit so ptr+off cannot overflow before the modulo-W wrap.
  assign sum   = {1'b0, i_ptr} + {1'b0, off};
  assign o_idx = IW'((sum >= (IW+1)'(W)) ? sum - (IW+1)'(W) : sum);

endmodule

// File: rtl/letc_core_limp_arbiter.sv
// letc_core_limp_arbiter: round-robin N-to-1 arbiter between LIMP requestors
// and the single LIMP servicer.
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_req_valid/o_req_ready per-requestor handshake (ready = completion pulse)
//   i_req                   per-requestor request fields
//   o_req_rdata/o_req_fault shared response, qualified by the o_req_ready bit
//   o_svc_valid/i_svc_ready servicer handshake
//   o_svc_req               registered request of the granted requestor
//   i_svc_rdata/i_svc_fault servicer response, qualified by i_svc_ready
// With TIMEOUT_CYCLES > 0 a transaction stalled that many BUSY cycles is
// completed upstream with a fault; the servicer is still held until it
// finally answers (ABORT), and that late answer is dropped.
module letc_core_limp_arbiter
  import letc_core_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic      [NUM_REQ-1:0] i_req_valid,
  output logic      [NUM_REQ-1:0] o_req_ready,
  input  limp_req_t [NUM_REQ-1:0] i_req,
  output word_t                   o_req_rdata,
  output logic                    o_req_fault,
  output logic                    o_svc_valid,
  input  logic                    i_svc_ready,
  output limp_req_t               o_svc_req,
  input  word_t                   i_svc_rdata,
  input  logic                    i_svc_fault
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = idx_width(TIMEOUT_CYCLES);
  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  limp_arb_state_e  state_q, state_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  limp_req_t        svc_req_q, svc_req_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic [IDX_W-1:0] grant_next;

  letc_core_rr_picker #(.W(NUM_REQ)) u_picker (
    .i_req   (i_req_valid),
    .i_ptr   (rr_ptr_q),
    .o_idx   (pick_idx),
    .o_found (pick_found)
  );

  // Requestor after the current grant gets first pick next time.
  assign grant_next = (grant_idx_q == IDX_LAST) ? '0 : grant_idx_q + IDX_W'(1);

  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    rr_ptr_d    = rr_ptr_q;
    tmo_cnt_d   = tmo_cnt_q;
    svc_req_d   = svc_req_q;
    o_req_ready = '0;
    o_req_rdata = '0;
    o_req_fault = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d     = ARB_BUSY;
          grant_idx_d = pick_idx;
          svc_req_d   = i_req[pick_idx];
          tmo_cnt_d   = '0;
        end
      end

      ARB_BUSY: begin
        // A servicer answer in the last allowed cycle beats the timeout.
        if (i_svc_ready) begin
          o_req_ready[grant_idx_q] = 1'b1;
          o_req_rdata              = i_svc_rdata;
          o_req_fault              = i_svc_fault;
          state_d                  = ARB_IDLE;
          rr_ptr_d                 = grant_next;
        end else if (TMO_EN && (tmo_cnt_q == CNT_LAST)) begin
          o_req_ready[grant_idx_q] = 1'b1;
          o_req_fault              = 1'b1;
          state_d                  = ARB_ABORT;
        end else if (TMO_EN) begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
      end

      ARB_ABORT: begin
        // Requestor already completed with a fault; swallow the late answer.
        if (i_svc_ready) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = grant_next;
        end
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ARB_IDLE;
      grant_idx_q <= '0;
      rr_ptr_q    <= '0;
      tmo_cnt_q   <= '0;
      svc_req_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      tmo_cnt_q   <= tmo_cnt_d;
      svc_req_q   <= svc_req_d;
    end
  end

  assign o_svc_valid = (state_q != ARB_IDLE);
  assign o_svc_req   = svc_req_q;

`ifdef SIMULATION
  a_ready_onehot0: assert property (@(posedge i_clk) disable iff (i_rst)
    $onehot0(o_req_ready));

  a_svc_req_stable: assert property (@(posedge i_clk) disable iff (i_rst)
    (o_svc_valid && !i_svc_ready) |=> $stable(o_svc_req));

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_hold
    a_valid_hold: assert property (@(posedge i_clk) disable iff (i_rst)
      (i_req_valid[g] && !o_req_ready[g]) |=> i_req_valid[g]);
  end
`endif

endmodule

// File: tb/tb_letc_core_limp_arbiter.sv
// Bench for letc_core_limp_arbiter: dut_a (3 requestors, no timeout) and
// dut_t (2 requestors, 4-cycle timeout). Directed stimulus pushes expected
// completions into per-DUT queues; negedge monitors pop and compare.
`timescale 1ns/1ps
module tb_letc_core_limp_arbiter;
  import letc_core_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic      [2:0] a_valid, a_ready;
  limp_req_t [2:0] a_req;
  word_t           a_rdata, a_svc_rdata;
  logic            a_fault, a_svc_valid, a_svc_ready, a_svc_fault;
  limp_req_t       a_svc_req;

  logic      [1:0] t_valid, t_ready;
  limp_req_t [1:0] t_req;
  word_t           t_rdata, t_svc_rdata;
  logic            t_fault, t_svc_valid, t_svc_ready, t_svc_fault;
  limp_req_t       t_svc_req;

  letc_core_limp_arbiter #(.NUM_REQ(3), .TIMEOUT_CYCLES(0)) dut_a (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(a_valid), .o_req_ready(a_ready), .i_req(a_req),
    .o_req_rdata(a_rdata), .o_req_fault(a_fault),
    .o_svc_valid(a_svc_valid), .i_svc_ready(a_svc_ready), .o_svc_req(a_svc_req),
    .i_svc_rdata(a_svc_rdata), .i_svc_fault(a_svc_fault)
  );

  letc_core_limp_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(4)) dut_t (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(t_valid), .o_req_ready(t_ready), .i_req(t_req),
    .o_req_rdata(t_rdata), .o_req_fault(t_fault),
    .o_svc_valid(t_svc_valid), .i_svc_ready(t_svc_ready), .o_svc_req(t_svc_req),
    .i_svc_rdata(t_svc_rdata), .i_svc_fault(t_svc_fault)
  );

  typedef struct {
    logic [2:0] ready;
    word_t      rdata;
    logic       fault;
    int         cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qt[$];
  exp_t ea, et;
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_a(input logic [2:0] r, input word_t d, input logic f, input int c);
    exp_t e;
    e.ready = r; e.rdata = d; e.fault = f; e.cyc = c;
    qa.push_back(e);
  endtask

  task automatic push_t(input logic [2:0] r, input word_t d, input logic f, input int c);
    exp_t e;
    e.ready = r; e.rdata = d; e.fault = f; e.cyc = c;
    qt.push_back(e);
  endtask

  function automatic limp_req_t mk_req(input logic wen, input paddr_t addr, input word_t wdata);
    limp_req_t r;
    r.wen_nren = wen; r.uncacheable = 1'b0; r.size = SIZE_WORD;
    r.addr = addr; r.wdata = wdata;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: every completion pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (cyc > 0 && a_ready !== 3'b000) begin
      if (qa.size() == 0) chk("a_unexpected_ready", a_ready, 0);
      else begin
        ea = qa.pop_front();
        chk("a_ready_vec", a_ready, ea.ready);
        chk("a_rdata", a_rdata, ea.rdata);
        chk("a_fault", a_fault, ea.fault);
        chk("a_ready_cycle", cyc, ea.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0 && t_ready !== 2'b00) begin
      if (qt.size() == 0) chk("t_unexpected_ready", t_ready, 0);
      else begin
        et = qt.pop_front();
        chk("t_ready_vec", {1'b0, t_ready}, et.ready);
        chk("t_rdata", t_rdata, et.rdata);
        chk("t_fault", t_fault, et.fault);
        chk("t_ready_cycle", cyc, et.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int        base;
    limp_req_t wreq;

    a_valid = '0; a_req = '0; a_svc_ready = 1'b0; a_svc_rdata = '0; a_svc_fault = 1'b0;
    t_valid = '0; t_req = '0; t_svc_ready = 1'b0; t_svc_rdata = '0; t_svc_fault = 1'b0;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_a_svc_valid", a_svc_valid, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_a_fault", a_fault, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_a_svc_req", a_svc_req, 0);
    chk("rst_t_svc_valid", t_svc_valid, 0);
    chk("rst_t_svc_req", t_svc_req, 0);
    tick();
    rst = 1'b0;

    // T1: single read, servicer ready immediately -> ready one cycle later
    t_req[0] = mk_req(1'b0, 34'h1000, '0);
    t_valid = 2'b01; t_svc_ready = 1'b1; t_svc_rdata = 32'hDEADBEEF;
    push_t(3'b001, 32'hDEADBEEF, 1'b0, cyc + 1);
    tick();
    @(negedge clk);
    chk("t1_svc_valid", t_svc_valid, 1);
    chk("t1_svc_addr", t_svc_req.addr, 34'h1000);
    tick();
    t_valid = '0; t_svc_ready = 1'b0; t_svc_rdata = '0;
    tick();

    // T2: three requestors always valid, servicer always ready -> 0,1,2,0,1,2
    base = cyc;
    a_req[0] = mk_req(1'b0, 34'h100, '0);
    a_req[1] = mk_req(1'b0, 34'h200, '0);
    a_req[2] = mk_req(1'b0, 34'h300, '0);
    a_valid = 3'b111; a_svc_ready = 1'b1; a_svc_rdata = 32'hA5A50001;
    push_a(3'b001, 32'hA5A50001, 1'b0, base + 1);
    push_a(3'b010, 32'hA5A50001, 1'b0, base + 3);
    push_a(3'b100, 32'hA5A50001, 1'b0, base + 5);
    push_a(3'b001, 32'hA5A50001, 1'b0, base + 7);
    push_a(3'b010, 32'hA5A50001, 1'b0, base + 9);
    push_a(3'b100, 32'hA5A50001, 1'b0, base + 11);
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 8)  a_valid[0] = 1'b0;
      if (k == 10) a_valid[1] = 1'b0;
      if (k == 12) a_valid[2] = 1'b0;
    end
    a_svc_ready = 1'b0; a_svc_rdata = '0;
    tick();

    // T3: req1 write, servicer stalls 5 cycles then answers with a fault
    base = cyc;
    wreq = mk_req(1'b1, 34'h2000, 32'h12345678);
    a_req[1] = wreq;
    a_valid = 3'b010;
    push_a(3'b010, 32'h0BADF00D, 1'b1, base + 6);
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 6) begin
        a_svc_ready = 1'b1; a_svc_fault = 1'b1; a_svc_rdata = 32'h0BADF00D;
      end
      @(negedge clk);
      chk("t3_svc_valid", a_svc_valid, 1);
      chk("t3_svc_req", a_svc_req, wreq);
    end
    tick();
    a_valid = '0; a_svc_ready = 1'b0; a_svc_fault = 1'b0; a_svc_rdata = '0;
    tick();

    // T4: timeout=4, servicer answers after 10 cycles; req1 waits through ABORT
    base = cyc;
    t_req[0] = mk_req(1'b0, 34'h3000, '0);
    t_req[1] = mk_req(1'b0, 34'h4000, '0);
    t_valid = 2'b01; t_svc_ready = 1'b0; t_svc_rdata = 32'hFFFFFFFF;
    push_t(3'b001, 32'h0, 1'b1, base + 4);
    push_t(3'b010, 32'h11112222, 1'b0, base + 12);
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 5)  t_valid[0] = 1'b0;
      if (k == 6)  t_valid[1] = 1'b1;
      if (k == 10) t_svc_ready = 1'b1;
      if (k == 11) begin t_svc_ready = 1'b0; t_svc_rdata = 32'h11112222; end
      if (k == 12) t_svc_ready = 1'b1;
      @(negedge clk);
      if (k <= 10) chk("t4_svc_valid_held", t_svc_valid, 1);
      if (k == 11) chk("t4_idle_after_abort", t_svc_valid, 0);
      if (k == 12) chk("t4_next_grant_addr", t_svc_req.addr, 34'h4000);
    end
    tick();
    t_valid = '0; t_svc_ready = 1'b0; t_svc_rdata = '0;
    tick();

    // T5: timeout=4, servicer answers in the 4th BUSY cycle -> normal completion
    base = cyc;
    t_req[0] = mk_req(1'b0, 34'h5000, '0);
    t_valid = 2'b01; t_svc_rdata = 32'hCAFEF00D;
    push_t(3'b001, 32'hCAFEF00D, 1'b0, base + 4);
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 4) t_svc_ready = 1'b1;
      if (k == 5) begin t_valid = '0; t_svc_ready = 1'b0; end
      @(negedge clk);
      if (k == 5) chk("t5_no_abort", t_svc_valid, 0);
    end
    t_svc_rdata = '0;
    tick();

    // T6: reset while BUSY, then simultaneous 0/1 request -> 0 wins (pointer reset)
    base = cyc;
    t_req[0] = mk_req(1'b0, 34'h6000, '0);
    t_valid = 2'b01;
    tick();
    @(negedge clk);
    chk("t6_busy_before_rst", t_svc_valid, 1);
    tick();
    rst = 1'b1; t_valid = '0;
    tick();
    @(negedge clk);
    chk("t6_rst_svc_valid", t_svc_valid, 0);
    chk("t6_rst_ready", t_ready, 0);
    chk("t6_rst_svc_req", t_svc_req, 0);
    rst = 1'b0;
    t_req[1] = mk_req(1'b0, 34'h7000, '0);
    t_valid = 2'b11; t_svc_ready = 1'b1; t_svc_rdata = 32'h600D600D;
    push_t(3'b001, 32'h600D600D, 1'b0, base + 4);
    push_t(3'b010, 32'h600D600D, 1'b0, base + 6);
    for (int k = 4; k <= 7; k++) begin
      tick();
      if (k == 5) t_valid[0] = 1'b0;
      if (k == 7) begin t_valid[1] = 1'b0; t_svc_ready = 1'b0; end
    end

    repeat (3) tick();
    chk("a_queue_empty", qa.size(), 0);
    chk("t_queue_empty", qt.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
